btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer for the fetch stage; successor to the fixed 2-way BTB.
- Each line covers BLOCK consecutive instructions. Each slot carries its own valid bit, target and branch type.
- Lookup is registered, with 1-cycle latency. Commit-time updates hit the matching way before allocating a new one. Replacement picks the first invalid way, else a per-set round-robin victim.
- Reset and flush run an invalidation sweep FSM, one set per cycle, so the arrays need no reset.

Parameters:
WAYS, 4, associativity (power of two, ≥2)
BLOCK, 4, instruction slots per line (power of two)
INDEX_WIDTH, 4, log2 of set count
TYPE_WIDTH, 2, branch-type field width
Derived: BLOCK_WIDTH=$clog2(BLOCK), OFFSET=2, TAG_WIDTH=32-OFFSET-BLOCK_WIDTH-INDEX_WIDTH

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
rd_en  in  1  lookup request
rd_pc  in  32  lookup PC; slot field is ignored, whole line returned
rd_valid  out  1  lookup result valid (cycle after rd_en)
rd_hit  out  1  tag match in a valid way
rd_slot_valid  out  BLOCK  per-slot valid of the hit line
rd_npc  out  BLOCK x 32  per-slot target
rd_br_type  out  BLOCK x TYPE_WIDTH  per-slot branch type
commit  in  1  update request from retire
commit_pc  in  32  PC of the retired branch
commit_type  in  TYPE_WIDTH  branch type
commit_npc  in  32  resolved target
flush  in  1  invalidate the whole BTB
busy  out  1  sweep in progress

Behaviour:
- PC split: slot = pc[OFFSET+BLOCK_WIDTH-1:OFFSET]; index = next INDEX_WIDTH bits; tag = remaining upper bits.
- Storage per way/set: way valid, tag, BLOCK x {slot valid, type, npc}. Plus one round-robin pointer per set, $clog2(WAYS) bits wide.
- FSM states: SWEEP, RUN.
  - reset → SWEEP with sweep counter 0.
  - In SWEEP, each cycle clears way valid and all slot valids for every way of set[counter], and clears that set's RR pointer. Then counter++.
  - SWEEP → RUN after set 2^INDEX_WIDTH-1 is cleared. Duration is exactly 2^INDEX_WIDTH cycles.
  - flush in any state → SWEEP with counter 0; a flush during a sweep restarts it.
  - busy = (state==SWEEP).
- Reset values: state SWEEP, busy 1, rd_valid 0, rd_hit 0, rd_slot_valid 0, rd_npc 0, rd_br_type 0. Array contents are not reset.
- Lookup:
  - rd_en at cycle t → outputs registered at t+1; rd_valid=1 for exactly one cycle per request. Back-to-back requests are accepted every cycle.
  - Hit = exactly one way with way valid and tag equal; outputs come from that way.
  - On a miss, or when rd_en is sampled while busy: rd_valid=1, rd_hit=0, and all data outputs are 0.
  - When rd_en=0, rd_valid=0 and the data outputs hold their previous values.
- Commit, only when not busy; commit while busy or with flush is dropped. Takes effect at the clock edge.
  - Tag hit in way w: write type/npc into slot, set slot valid, leave other slots untouched. No allocation; RR pointer unchanged.
  - Miss with an invalid way: use the lowest-numbered invalid way.
  - Miss with all ways valid: use way = RR pointer, then pointer++ (wraps modulo WAYS).
  - Allocation writes the tag, sets way valid, clears all other slot valids, and writes the committed slot.
- Same cycle rd_en and commit to the same line: the lookup returns pre-commit contents (read-before-write).
- By construction no two ways in a set hold the same valid tag. The implementation adds an assertion for this.
- flush and reset take priority over everything.

Decomposition:
- Package btb_pkg:
  - br_type_e (BR_NONE=0, BR_COND=1, BR_JUMP=2, BR_RET=3)
  - slot_t {valid, type, npc}
  - line_t {valid, tag, slot_t[BLOCK]}
  - state_e {SWEEP, RUN}
  - OFFSET constant
  - pc field-extract functions
- Sub-module btb_victim_sel: combinational; inputs are way valids, per-way tag-hit vector and RR pointer; outputs are the selected way index and the advance-pointer flag.

Test Plan:
1. Deassert reset → busy=1 for exactly 16 cycles. rd_en with rd_pc=0x0000_1000 during busy → rd_valid=1, rd_hit=0. The same read after busy drops also misses.
2. Commit pc=0x0000_1004, type=1, npc=0x0000_2000, then read 0x0000_1000 → rd_hit=1, rd_slot_valid=4'b0010, rd_npc[1]=0x2000, rd_br_type[1]=1.
3. Commits to 0x1000, 0x2000, 0x3000, 0x4000 (all index 0) fill ways 0–3. Commit 0x5000 evicts way 0 → read 0x1000 misses, reads 0x5000 and 0x2000 hit. A following commit 0x6000 evicts way 1 (0x2000).
4. Commit 0x1004 npc 0x2000, then 0x1004 npc 0x3000, then 0x100C npc 0x4000 → a single way holds the line: rd_slot_valid=4'b1010, rd_npc[1]=0x3000, rd_npc[3]=0x4000.
5. Same cycle: rd_en pc=0x1000 and commit pc=0x1000 on an empty BTB → that read misses, the next read hits.
6. Populate entries, pulse flush, then pulse flush again 5 cycles into the sweep → busy lasts 5+16 cycles, commits during busy are dropped, and all prior entries miss afterwards.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and PC field helpers for the
// set-associative branch target buffer.
package btb_pkg;

  localparam int OFFSET = 2;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic [31:0] pc_slot(
    input logic [31:0] pc,
    input int          bw
  );
    return (pc >> OFFSET) & ((32'd1 << bw) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_index(
    input logic [31:0] pc,
    input int          bw,
    input int          iw
  );
    return (pc >> (OFFSET + bw)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(
    input logic [31:0] pc,
    input int          bw,
    input int          iw
  );
    return pc >> (OFFSET + bw + iw);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// btb_assoc_if: lookup, commit and flush bundle between
// fetch/retire (master) and the BTB (slave).
interface btb_assoc_if #(
  parameter int BLOCK      = 4,
  parameter int TYPE_WIDTH = 2
);
  logic                                rd_en;
  logic [31:0]                         rd_pc;
  logic                                rd_valid;
  logic                                rd_hit;
  logic [BLOCK-1:0]                    rd_slot_valid;
  logic [BLOCK-1:0][31:0]              rd_npc;
  logic [BLOCK-1:0][TYPE_WIDTH-1:0]    rd_br_type;
  logic                                commit;
  logic [31:0]                         commit_pc;
  logic [TYPE_WIDTH-1:0]               commit_type;
  logic [31:0]                         commit_npc;
  logic                                flush;
  logic                                busy;

  modport master (
    output rd_en, rd_pc,
    output commit, commit_pc,
    output commit_type, commit_npc,
    output flush,
    input  rd_valid, rd_hit,
    input  rd_slot_valid, rd_npc,
    input  rd_br_type, busy
  );

  modport slave (
    input  rd_en, rd_pc,
    input  commit, commit_pc,
    input  commit_type, commit_npc,
    input  flush,
    output rd_valid, rd_hit,
    output rd_slot_valid, rd_npc,
    output rd_br_type, busy
  );
endinterface

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: picks the way a commit writes:
// tag hit, else lowest invalid way, else round-robin.
module btb_victim_sel #(
  parameter int WAYS = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAYS-1:0]  i_hit,
  input  logic [WAY_W-1:0] i_rr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_hit,
  output logic             o_adv
);

  always_comb begin
    o_way = i_rr;
    o_hit = |i_hit;
    o_adv = 1'b1;
    if (|i_hit) begin
      o_adv = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (i_hit[w]) o_way = WAY_W'(w);
    end else if (!(&i_valid)) begin
      o_adv = 1'b0;
      // descending scan leaves the lowest invalid way
      for (int w = WAYS - 1; w >= 0; w--)
        if (!i_valid[w]) o_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative BTB with registered
// lookup, commit-time update and a set-by-set sweep.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int BLOCK       = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int TYPE_WIDTH  = 2
) (
  input logic        clock,
  input logic        reset,
  btb_assoc_if.slave bus
);

  localparam int BLOCK_WIDTH = $clog2(BLOCK);
  localparam int TAG_WIDTH =
    32 - OFFSET - BLOCK_WIDTH - INDEX_WIDTH;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WAY_W = $clog2(WAYS);

  typedef struct packed {
    logic                  valid;
    logic [TYPE_WIDTH-1:0] btype;
    logic [31:0]           npc;
  } slot_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    slot_t [BLOCK-1:0]     slot;
  } line_t;

  line_t            r_line [WAYS][SETS];
  logic [WAY_W-1:0] r_rr   [SETS];

  state_e                 r_state, w_state_nx;
  logic [INDEX_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic                   w_busy;

  assign w_busy   = (r_state == SWEEP);
  assign bus.busy = w_busy;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (bus.flush) begin
      w_state_nx = SWEEP;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        SWEEP: begin
          w_cnt_nx = r_cnt + 1'b1;
          if (&r_cnt) w_state_nx = RUN;
        end
        RUN: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  logic [31:0]            w_rd_idx32, w_rd_tag32;
  logic [INDEX_WIDTH-1:0] w_rd_idx;
  logic [TAG_WIDTH-1:0]   w_rd_tag;
  logic [WAYS-1:0]        w_rd_hit;
  line_t                  w_rd_line;
  logic                   w_rd_ok;

  assign w_rd_idx32 =
    pc_index(bus.rd_pc, BLOCK_WIDTH, INDEX_WIDTH);
  assign w_rd_tag32 =
    pc_tag(bus.rd_pc, BLOCK_WIDTH, INDEX_WIDTH);
  assign w_rd_idx = w_rd_idx32[INDEX_WIDTH-1:0];
  assign w_rd_tag = w_rd_tag32[TAG_WIDTH-1:0];

  always_comb begin
    w_rd_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_rd_hit[w] = r_line[w][w_rd_idx].valid &&
        (r_line[w][w_rd_idx].tag == w_rd_tag);
      // tags are unique per set, so an OR-mux is enough
      if (w_rd_hit[w])
        w_rd_line = w_rd_line | r_line[w][w_rd_idx];
    end
  end

  assign w_rd_ok = !w_busy && !bus.flush && (|w_rd_hit);

  logic                              r_rd_valid;
  logic                              r_rd_hit;
  logic [BLOCK-1:0]                  r_rd_sv;
  logic [BLOCK-1:0][31:0]            r_rd_npc;
  logic [BLOCK-1:0][TYPE_WIDTH-1:0]  r_rd_type;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_sv    <= '0;
      r_rd_npc   <= '0;
      r_rd_type  <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_hit <= w_rd_ok;
        for (int s = 0; s < BLOCK; s++) begin
          r_rd_sv[s] <=
            w_rd_ok & w_rd_line.slot[s].valid;
          r_rd_npc[s] <=
            w_rd_ok ? w_rd_line.slot[s].npc : '0;
          r_rd_type[s] <=
            w_rd_ok ? w_rd_line.slot[s].btype : '0;
        end
      end
    end
  end

  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_hit        = r_rd_hit;
  assign bus.rd_slot_valid = r_rd_sv;
  assign bus.rd_npc        = r_rd_npc;
  assign bus.rd_br_type    = r_rd_type;

  logic [31:0]            w_cm_idx32, w_cm_tag32;
  logic [31:0]            w_cm_slot32;
  logic [INDEX_WIDTH-1:0] w_cm_idx;
  logic [TAG_WIDTH-1:0]   w_cm_tag;
  logic [BLOCK_WIDTH-1:0] w_cm_slot;
  logic [WAYS-1:0]        w_cm_valid, w_cm_hit;
  logic [WAY_W-1:0]       w_way;
  logic                   w_way_hit, w_adv, w_cm_ok;
  line_t                  w_new;

  assign w_cm_idx32 =
    pc_index(bus.commit_pc, BLOCK_WIDTH, INDEX_WIDTH);
  assign w_cm_tag32 =
    pc_tag(bus.commit_pc, BLOCK_WIDTH, INDEX_WIDTH);
  assign w_cm_slot32 =
    pc_slot(bus.commit_pc, BLOCK_WIDTH);
  assign w_cm_idx  = w_cm_idx32[INDEX_WIDTH-1:0];
  assign w_cm_tag  = w_cm_tag32[TAG_WIDTH-1:0];
  assign w_cm_slot = w_cm_slot32[BLOCK_WIDTH-1:0];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_cm_valid[w] = r_line[w][w_cm_idx].valid;
      w_cm_hit[w]   = w_cm_valid[w] &&
        (r_line[w][w_cm_idx].tag == w_cm_tag);
    end
  end

  btb_victim_sel #(
    .WAYS (WAYS)
  ) u_victim (
    .i_valid (w_cm_valid),
    .i_hit   (w_cm_hit),
    .i_rr    (r_rr[w_cm_idx]),
    .o_way   (w_way),
    .o_hit   (w_way_hit),
    .o_adv   (w_adv)
  );

  always_comb begin
    w_new = r_line[w_way][w_cm_idx];
    if (!w_way_hit) begin
      w_new.valid = 1'b1;
      w_new.tag   = w_cm_tag;
      for (int s = 0; s < BLOCK; s++)
        w_new.slot[s].valid = 1'b0;
    end
    w_new.slot[w_cm_slot] =
      {1'b1, bus.commit_type, bus.commit_npc};
  end

  assign w_cm_ok = bus.commit && !w_busy && !bus.flush;

  always_ff @(posedge clock) begin
    if (!reset && !bus.flush) begin
      if (w_busy) begin
        for (int w = 0; w < WAYS; w++) begin
          r_line[w][r_cnt].valid <= 1'b0;
          for (int s = 0; s < BLOCK; s++)
            r_line[w][r_cnt].slot[s].valid <= 1'b0;
        end
        r_rr[r_cnt] <= '0;
      end else if (w_cm_ok) begin
        r_line[w_way][w_cm_idx] <= w_new;
        if (w_adv)
          r_rr[w_cm_idx] <= r_rr[w_cm_idx] + 1'b1;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{
    w_rd_idx32[31:INDEX_WIDTH],
    w_rd_tag32[31:TAG_WIDTH],
    w_cm_idx32[31:INDEX_WIDTH],
    w_cm_tag32[31:TAG_WIDTH],
    w_cm_slot32[31:BLOCK_WIDTH]
  };

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && !w_busy) begin
      assert ($onehot0(w_rd_hit))
        else $error("btb: duplicate tag in lookup set");
      assert ($onehot0(w_cm_hit))
        else $error("btb: duplicate tag in commit set");
    end
  end
`endif

endmodule
